ascii_char_fifo: RTL
====================

// Module: ascii_char_fifo
// PURPOSE
//  Elastic byte buffer that sits directly upstream of the combinational toupper
//  converter. It accepts 8-bit ASCII characters from a producer over a
//  valid/ready handshake and stores up to DEPTH of them. It presents the oldest
//  character to the converter stage, together with two flags: a lowercase
//  classification and an end-of-line flag. It also counts the line terminators
//  it has delivered.
// PARAMETERS
//  DEPTH   8   number of character entries; power of two, >= 2
//  ADDR_W  3   pointer width, log2(DEPTH)
//  LCNT_W  8   width of the delivered-line counter
// PORTS
//  clk           input   1       rising-edge clock
//  rst           input   1       synchronous, active-high reset
//  flush         input   1       synchronous clear of buffer contents; counter is kept
//  in_valid      input   1       producer has a character on in_char
//  in_ready      output  1       buffer can accept a character this cycle
//  in_char       input   8       ASCII character in; bit 7 is the MSB
//  out_valid     output  1       out_char holds a valid character
//  out_ready     input   1       downstream converter consumes out_char this cycle
//  out_char      output  8       oldest stored character (first-word fall-through)
//  out_is_lower  output  1       out_char is in the range 0x61..0x7A inclusive
//  out_eol       output  1       out_char == 0x0A
//  level         output  ADDR_W+1  number of stored entries, 0..DEPTH
//  line_count    output  LCNT_W  count of 0x0A characters popped, modulo 2^LCNT_W
// BEHAVIOUR
//  Reset (rst=1 at a rising edge):
//   - Pointers and level are set to 0, and line_count is set to 0.
//   - Outputs next cycle: in_ready=1, out_valid=0, level=0, line_count=0.
//   - out_char, out_is_lower and out_eol are 0 while out_valid=0.
//   - Storage RAM contents are not cleared.
//   - rst has priority over flush and over any handshake in the same cycle.
//   - Reset during streaming discards all stored characters; no pop is counted.
//  Handshake:
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (level != DEPTH). It is combinational from registered state
//     only and never depends on out_ready, so there is no full-state bypass.
//   - out_valid = (level != 0).
//   - in_char is written at mem[wr_ptr] on push, and wr_ptr increments.
//   - On pop, rd_ptr increments.
//   - Pointers wrap DEPTH-1 -> 0 naturally (ADDR_W bits).
//   - level: +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Latency: a character pushed into an empty buffer appears on out_char with
//     out_valid=1 in the cycle after the push edge. There is no same-cycle
//     pass-through.
//   - out_char, out_is_lower and out_eol are combinational decodes of mem[rd_ptr].
//     They stay stable while out_valid=1 and out_ready=0.
//  Boundaries:
//   - Full (level=DEPTH): in_ready=0, so an in_valid character is not taken.
//     The producer must hold it. A pop in this cycle lets in_ready rise next cycle.
//   - Empty (level=0): out_ready is ignored; level never goes below 0.
//   - Push and pop in the same cycle at 0<level<DEPTH: both take effect and
//     level holds.
//   - flush=1 (without rst) sets pointers and level to 0 at the edge.
//     Any push or pop in that cycle is discarded, and line_count is unchanged.
//  line_count:
//   - Increments by 1 on each pop where out_eol=1.
//   - Wraps 2^LCNT_W-1 -> 0 with no sticky flag.
//  Classification:
//   - out_is_lower = (c >= 8'h61) & (c <= 8'h7A).
//   - 8'h60 ('`') and 8'h7B ('{') give 0.
//   - Bytes with bit 7 set give 0.
// TESTING
//  1. Reset:
//     - Stimulus: rst=1 for 2 cycles with in_valid=1 and in_char=8'h61.
//     - Required: level=0, out_valid=0, in_ready=1, line_count=0 throughout.
//  2. Fill and overflow hold:
//     - Stimulus: push 0x41..0x48 with out_ready=0, then present 0x49.
//     - Required: in_ready=0 after the 8th push and level=8.
//     - Required: 0x49 is not stored; popping gives 0x41..0x48 in order,
//       and 0x49 is accepted afterwards.
//  3. Classification:
//     - Stimulus: pass 0x60, 0x61, 0x7A, 0x7B, 0xE1.
//     - Required: out_is_lower = 0, 1, 1, 0, 0 respectively.
//  4. Concurrent push/pop:
//     - Stimulus: at level=4, run 20 cycles with in_valid=1 and out_ready=1.
//     - Required: level stays 4, and the output order equals the input order
//       across pointer wrap.
//  5. Line counter wrap:
//     - Stimulus: stream 257 characters of 0x0A with out_ready=1.
//     - Required: line_count reads 255 after 255 pops, then 0, then 1.
//     - Required: out_eol=1 on every valid cycle.
//  6. Flush and reset mid-stream:
//     - Stimulus: at level=5, pulse flush together with push and pop.
//     - Required: next cycle level=0, out_valid=0, and line_count is unchanged.
//     - Stimulus: refill to 3, then pulse rst.
//     - Required: level=0 and line_count=0.

Source files
------------

// File: rtl/ascii_char_fifo_if.sv
// ascii_char_fifo_if: producer/consumer handshake bundle for the ASCII character FIFO.
interface ascii_char_fifo_if #(
    parameter int ADDR_W = 3,
    parameter int LCNT_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_char;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_char;
    logic              out_is_lower;
    logic              out_eol;
    logic [ADDR_W:0]   level;
    logic [LCNT_W-1:0] line_count;

    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_char, out_is_lower, out_eol, level, line_count
    );
    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_char, out_is_lower, out_eol, level, line_count
    );
endinterface

// File: rtl/ascii_char_fifo.sv
// ascii_char_fifo: first-word fall-through byte FIFO with lowercase/EOL decode and delivered-line counter.
module ascii_char_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int LCNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    ascii_char_fifo_if.slave bus
);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [LCNT_W-1:0] lcnt;
    logic [7:0]        head;
    logic              push, pop;

    assign head           = mem[rd_ptr];
    assign bus.in_ready   = cnt != (ADDR_W+1)'(DEPTH);
    assign bus.out_valid  = cnt != '0;
    assign bus.level      = cnt;
    assign bus.line_count = lcnt;
    assign push           = bus.in_valid & bus.in_ready;
    assign pop            = bus.out_valid & bus.out_ready;

    // Decodes are forced to zero while empty so stale RAM never leaks out
    always_comb begin
        bus.out_char     = bus.out_valid ? head : 8'h00;
        bus.out_is_lower = bus.out_valid && head >= 8'h61 && head <= 8'h7A;
        bus.out_eol      = bus.out_valid && head == 8'h0A;
    end

    always_ff @(posedge clk)
        if (push && !rst && !flush)
            mem[wr_ptr] <= bus.in_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            lcnt   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (pop && bus.out_eol)
                lcnt <= lcnt + 1'b1;
            cnt <= cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end
endmodule
